// File: rtl/led_anim_pkg.sv
// Shared types, widths and the colour-scaling helper for the LED strip animator.
package led_anim_pkg;

  localparam int COLOR_W = 24;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_CLEAR = 2'd3
  } anim_state_t;

  // Each 8-bit channel becomes (c * (b + 1)) >> 8, so b = 255 is the identity.
  function automatic logic [COLOR_W-1:0] scale_color(input logic [COLOR_W-1:0] c,
                                                     input logic [7:0]         b);
    logic [COLOR_W-1:0] r;
    logic [16:0]        p;
    logic [8:0]         m;
    m = {1'b0, b} + 9'd1;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      p = {9'd0, c[i*8 +: 8]} * {8'd0, m};
      r[i*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_frame_timer.sv
// Frame timer: counts TICK_CYCLES clocks while run_i is high and pulses tick_o on the last one.
module led_frame_timer #(
  parameter int TICK_CYCLES = 24'hFF0000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (run_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_strip_animator.sv
// Chase / bounce / fill animation sequencer issuing single-LED writes to a WS2812B driver.
// Optional brightness scaling of written colours is enabled with ANIM_BRIGHTNESS_EN.
module led_strip_animator
  import led_anim_pkg::*;
#(
  parameter  int NB_LEDS     = 15,
  parameter  int TICK_CYCLES = 24'hFF0000,
  localparam int POS_W       = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               drv_ready,
`ifdef ANIM_BRIGHTNESS_EN
  input  logic [7:0]         brightness,
`endif
  output logic [COLOR_W-1:0] led_color,
  output logic [31:0]        led_number,
  output logic               led_write,
  output logic [POS_W-1:0]   position,
  output logic               frame_tick,
  output anim_state_t        dbg_state
);

  localparam logic [POS_W-1:0] LAST = POS_W'(NB_LEDS - 1);

  anim_state_t        state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [COLOR_W-1:0] fg_q, fg_d, bg_q, bg_d;
  logic [POS_W-1:0]   pos_q, pos_d, clr_q, clr_d;
  logic               dir_up_q, dir_up_d, full_q, full_d;
  logic [COLOR_W-1:0] color_q, color_d, wr_color, wr_scaled;
  logic [31:0]        number_q, number_d;
  logic [POS_W-1:0]   wr_idx, nxt_pos;
  logic               nxt_dir_up, tick, accept, wr;

  led_frame_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run_i  ((state_q == S_WAIT) && enable),
    .tick_o (tick)
  );

  // Ping-pong turns on the endpoint itself, so an endpoint is never drawn twice in a row.
  always_comb begin
    nxt_pos    = pos_q;
    nxt_dir_up = dir_up_q;
    if (NB_LEDS > 1) begin
      if (mode_q == MODE_BOUNCE) begin
        if (dir_up_q) begin
          if (pos_q == LAST) begin
            nxt_pos    = pos_q - 1'b1;
            nxt_dir_up = 1'b0;
          end else begin
            nxt_pos = pos_q + 1'b1;
          end
        end else begin
          if (pos_q == '0) begin
            nxt_pos    = pos_q + 1'b1;
            nxt_dir_up = 1'b1;
          end else begin
            nxt_pos = pos_q - 1'b1;
          end
        end
      end else begin
        nxt_pos = (pos_q == LAST) ? '0 : pos_q + 1'b1;
      end
    end
  end

  // Handshake: a write state presents led_write only in a cycle where drv_ready is high,
  // and that cycle is the transfer; with drv_ready low the FSM holds and led_write stays 0.
  assign accept = drv_ready && !rst;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    pos_d    = pos_q;
    clr_d    = clr_q;
    dir_up_d = dir_up_q;
    full_d   = full_q;
    wr       = 1'b0;
    wr_color = bg_q;
    wr_idx   = pos_q;
    case (state_q)
      S_WAIT: begin
        if (tick) begin
          mode_d = mode_t'(mode);
          fg_d   = fg_color;
          bg_d   = bg_color;
          if (mode_t'(mode) != mode_q) begin
            state_d = S_CLEAR;
          end else begin
            case (mode_t'(mode))
              MODE_CHASE, MODE_BOUNCE: state_d = S_ERASE;
              MODE_FILL:               state_d = full_q ? S_CLEAR : S_DRAW;
              default:                 state_d = S_WAIT;
            endcase
          end
        end
      end
      S_ERASE: begin
        if (accept) begin
          wr       = 1'b1;
          pos_d    = nxt_pos;
          dir_up_d = nxt_dir_up;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        wr_color = fg_q;
        if (accept) begin
          wr      = 1'b1;
          state_d = S_WAIT;
          if (mode_q == MODE_FILL) begin
            if (pos_q == LAST) full_d = 1'b1;
            else               pos_d  = pos_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        wr_idx = clr_q;
        if (accept) begin
          wr = 1'b1;
          if (clr_q == LAST) begin
            clr_d    = '0;
            pos_d    = '0;
            dir_up_d = 1'b1;
            full_d   = 1'b0;
            state_d  = S_WAIT;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

`ifdef ANIM_BRIGHTNESS_EN
  assign wr_scaled = scale_color(wr_color, brightness);
`else
  assign wr_scaled = wr_color;
`endif

  assign color_d  = wr ? wr_scaled : color_q;
  assign number_d = wr ? 32'(wr_idx) : number_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      mode_q   <= MODE_OFF;
      fg_q     <= '0;
      bg_q     <= '0;
      pos_q    <= '0;
      clr_q    <= '0;
      dir_up_q <= 1'b1;
      full_q   <= 1'b0;
      color_q  <= '0;
      number_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      pos_q    <= pos_d;
      clr_q    <= clr_d;
      dir_up_q <= dir_up_d;
      full_q   <= full_d;
      color_q  <= color_d;
      number_q <= number_d;
    end
  end

  assign led_color  = color_d;
  assign led_number = number_d;
  assign led_write  = wr;
  assign position   = pos_q;
  assign frame_tick = tick;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_led_strip_animator.sv
// Directed bench for led_strip_animator (NB_LEDS=4, TICK_CYCLES=8) with a write scoreboard.
module tb_led_strip_animator;
  import led_anim_pkg::*;

  localparam int NB = 4;
  localparam int TK = 8;

  logic        clk = 1'b0;
  logic        rst, enable, drv_ready;
  logic [1:0]  mode;
  logic [23:0] fg_color, bg_color;
  logic [23:0] led_color;
  logic [31:0] led_number;
  logic        led_write, frame_tick;
  logic [1:0]  position;
  anim_state_t dbg_state;
`ifdef ANIM_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [55:0] exp_q[$];

  led_strip_animator #(.NB_LEDS(NB), .TICK_CYCLES(TK)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .drv_ready  (drv_ready),
`ifdef ANIM_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .led_color  (led_color),
    .led_number (led_number),
    .led_write  (led_write),
    .position   (position),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [23:0] c);
    exp_q.push_back({32'(idx), c});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d writes still pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int bounce_seq[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

  initial begin
    int n;
    int prev;
    rst = 1'b1; enable = 1'b0; drv_ready = 1'b1; mode = 2'd0;
    fg_color = '0; bg_color = '0;
`ifdef ANIM_BRIGHTNESS_EN
    brightness = 8'd255;
`endif

    // Scoreboard monitor: every presented write pops one expected {index, colour}.
    fork
      forever begin
        @(negedge clk);
        if (led_write === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got idx %0d colour %h, required no write", led_number, led_color);
          end else begin
            check("write", {led_number, led_color}, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_led_write", 56'(led_write), 56'(0));
    check("rst_led_color", 56'(led_color), 56'(0));
    check("rst_led_number", 56'(led_number), 56'(0));
    check("rst_position", 56'(position), 56'(0));
    check("rst_frame_tick", 56'(frame_tick), 56'(0));
    check("rst_state", 56'(dbg_state), 56'(S_CLEAR));

    // Release: 4 clear writes back to back, then 8 wait cycles ending in frame_tick
    for (int i = 0; i < NB; i++) push(i, 24'h0);
    step();
    rst = 1'b0; enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    check("first_tick_cycle", 56'(n), 56'(NB + TK));
    drain("boot_clear");

    // CHASE: clear on mode change, then bg@p, fg@p+1 per frame
    step();
    mode = 2'd1; fg_color = 24'h00FF00; bg_color = 24'h000000;
    for (int i = 0; i < NB; i++) push(i, 24'h000000);
    for (int k = 0; k < 5; k++) begin
      push(k % NB, 24'h000000);
      push((k + 1) % NB, 24'h00FF00);
      drain("chase_frame");
      check("chase_position", 56'(position), 56'((k + 1) % NB));
    end

    // BOUNCE
    step();
    mode = 2'd2; fg_color = 24'h123456; bg_color = 24'h010203;
    for (int i = 0; i < NB; i++) push(i, 24'h010203);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      push(prev, 24'h010203);
      push(bounce_seq[k], 24'h123456);
      drain("bounce_frame");
      check("bounce_position", 56'(position), 56'(bounce_seq[k]));
      prev = bounce_seq[k];
    end

    // FILL: fg at 0..3, then a clear, then fg@0 again
    step();
    mode = 2'd3; fg_color = 24'hAABBCC; bg_color = 24'h000000;
    for (int i = 0; i < NB; i++) push(i, 24'h000000);
    for (int i = 0; i < NB; i++) push(i, 24'hAABBCC);
    for (int i = 0; i < NB; i++) push(i, 24'h000000);
    push(0, 24'hAABBCC);
    drain("fill");

    // Driver stall during S_ERASE
    step();
    mode = 2'd1; fg_color = 24'h00FF00; bg_color = 24'h202020;
    for (int i = 0; i < NB; i++) push(i, 24'h202020);
    drain("stall_clear");
    step();
    drv_ready = 1'b0;
    push(0, 24'h202020);
    push(1, 24'h00FF00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state !== S_ERASE && n < 40);
    check("stall_reach_erase", 56'(dbg_state), 56'(S_ERASE));
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      check("stall_write", 56'(led_write), 56'(0));
      check("stall_hold", {led_number, led_color}, {32'd3, 24'h202020});
    end
    step();
    drv_ready = 1'b1;
    @(negedge clk);
    check("stall_release_write", {31'd0, led_write, led_number[23:0]}, {31'd0, 1'b1, 24'd0});
    drain("stall_frame");
    check("stall_position", 56'(position), 56'(1));

    // Reset while the clear is at index 2
    step();
    mode = 2'd0; bg_color = 24'h0A0B0C;
    push(0, 24'h0A0B0C);
    push(1, 24'h0A0B0C);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(led_write === 1'b1 && led_number == 32'd1) && n < 40);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_write", 56'(led_write), 56'(0));
    step();
    check("rst_mid_outputs", {led_number, led_color}, 56'd0);
    check("rst_mid_ctl", {51'd0, led_write, frame_tick, position, 1'b0}, 56'd0);
    check("rst_mid_state", 56'(dbg_state), 56'(S_CLEAR));
    for (int i = 0; i < NB; i++) push(i, 24'h000000);
    rst = 1'b0;
    drain("rst_reclear");

`ifdef ANIM_BRIGHTNESS_EN
    // Brightness scaling
    step();
    brightness = 8'd127; mode = 2'd3; fg_color = 24'hFF8040; bg_color = 24'h000000;
    for (int i = 0; i < NB; i++) push(i, 24'h000000);
    push(0, 24'h7F4020);
    drain("brightness");
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", 56'(exp_q.size()), 56'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
